// File: rtl/hash_wb.sv
// -----------------------------------------------------------------------------
// hash_wb : Wishbone register front-end for a block hash core (SHA-1/SHA-256).
//
// Buffers message words in two ping-pong banks. It hands each full bank to the
// hash core with a one-cycle start pulse. When the core signals completion, it
// captures the digest so software can read the digest back word by word.
//
// Ports
//   wb_clk_i, reset_n          clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i       Wishbone strobe / cycle / write enable
//   wbs_sel_i, wbs_adr_i       byte selects, byte address
//   wbs_dat_i / wbs_dat_o      write / read data
//   wbs_ack_o                  one-cycle acknowledge, the cycle after acceptance
//   core_start                 one-cycle start pulse to the hash core
//   core_block                 bank being hashed, word 0 at the LSBs
//   core_done, core_digest     completion pulse and digest from the core
//   core_loop                  round index from the core (status only)
//   done, irq                  digest available / done gated by IRQ enable
//
// Register map (byte offsets from BASE_ADDRESS)
//   0x00 NR  0x04 ID  0x08 MSG_IN  0x0C OPS  0x10 MSG_IN_IDX  0x14 DIGEST
// -----------------------------------------------------------------------------
module hash_wb #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
    parameter int          MSG_WORDS    = 16,
    parameter int          DIGEST_WORDS = 5,
    parameter logic [31:0] CTRL_ID      = 32'h5348_4131
) (
    input  logic                        wb_clk_i,
    input  logic                        reset_n,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic                        core_start,
    output logic [32*MSG_WORDS-1:0]     core_block,
    input  logic                        core_done,
    input  logic [32*DIGEST_WORDS-1:0]  core_digest,
    input  logic [6:0]                  core_loop,
    output logic                        done,
    output logic                        irq
);

    localparam int PTR_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int IDX_W = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MSG_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGEST_WORDS - 1);
    localparam logic [31:0] ERR_DATA = 32'h0FFF_FFEA;
    localparam logic [31:0] NR_REGS  = 32'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN} state_t;
    typedef enum logic [2:0] {
        REG_NR, REG_ID, REG_MSG_IN, REG_OPS, REG_MSG_IDX, REG_DIGEST, REG_NONE
    } reg_t;

    state_t            state;
    logic [31:0]       bank [2][MSG_WORDS];
    logic [1:0]        full_q;
    logic              fill_bank;
    logic [PTR_W-1:0]  fill_ptr;
    logic              run_bank;
    logic [31:0]       digest_q [DIGEST_WORDS];
    logic [IDX_W-1:0]  dig_idx;
    logic              on_q, irq_en_q, done_q, overflow_q;

    logic [31:0] offset;
    reg_t        reg_sel;
    logic        accept, wr_ok, msg_wr, idx_wr, ops_wr, dig_rd, soft_rst;
    logic        busy;
    logic [1:0]  full_cnt;
    logic [31:0] rd_data;

    // Address decode: anything outside the six word offsets is unmapped.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        offset  = wbs_adr_i - BASE_ADDRESS;
        reg_sel = REG_NONE;
        case (offset)
            32'h00:  reg_sel = REG_NR;
            32'h04:  reg_sel = REG_ID;
            32'h08:  reg_sel = REG_MSG_IN;
            32'h0C:  reg_sel = REG_OPS;
            32'h10:  reg_sel = REG_MSG_IDX;
            32'h14:  reg_sel = REG_DIGEST;
            default: reg_sel = REG_NONE;
        endcase
    end

    // An access is taken only while no ack is outstanding, so each strobe is
    // acknowledged exactly once.
    assign accept   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr_ok    = accept & wbs_we_i & (wbs_sel_i == 4'hF);
    assign msg_wr   = wr_ok & (reg_sel == REG_MSG_IN);
    assign idx_wr   = wr_ok & (reg_sel == REG_MSG_IDX);
    assign ops_wr   = wr_ok & (reg_sel == REG_OPS);
    assign soft_rst = ops_wr & wbs_dat_i[1];
    assign dig_rd   = accept & ~wbs_we_i & (reg_sel == REG_DIGEST) & done_q;

    assign busy     = (state != ST_IDLE);
    assign full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign done     = done_q;
    assign irq      = done_q & irq_en_q;

    always_comb begin
        rd_data = ERR_DATA;
        case (reg_sel)
            REG_NR:     rd_data = NR_REGS;
            REG_ID:     rd_data = CTRL_ID;
            REG_OPS:    rd_data = {17'b0, core_loop, full_cnt, busy, overflow_q,
                                   done_q, irq_en_q, 1'b0, on_q};
            REG_DIGEST: rd_data = done_q ? digest_q[dig_idx] : ERR_DATA;
            default:    rd_data = ERR_DATA;
        endcase
    end

    // The bank under hash is never written: the fill side only writes a
    // non-full bank, so core_block stays stable from START to core_done.
    always_comb begin
        core_block = '0;
        for (int w = 0; w < MSG_WORDS; w++)
            core_block[w*32 +: 32] = bank[run_bank][w];
    end

    // NOTE: all state here uses non-blocking assignments, so every branch reads
    // the pre-edge values and later statements win only for the same target.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            core_start <= 1'b0;
            full_q     <= '0;
            fill_bank  <= 1'b0;
            fill_ptr   <= '0;
            run_bank   <= 1'b0;
            dig_idx    <= '0;
            on_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            // NOTE: the message banks are cleared too, so core_block reads as
            // zero out of reset. This costs reset fan-out on the storage.
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < MSG_WORDS; w++)
                    bank[b][w] <= '0;
            for (int d = 0; d < DIGEST_WORDS; d++)
                digest_q[d] <= '0;
        end else begin
            core_start <= 1'b0;
            wbs_ack_o  <= accept;
            if (accept)
                wbs_dat_o <= wbs_we_i ? '0 : rd_data;

            if (msg_wr) begin
                if (full_q[fill_bank]) begin
                    overflow_q <= 1'b1;
                end else begin
                    bank[fill_bank][fill_ptr] <= wbs_dat_i;
                    if (fill_ptr == PTR_LAST) begin
                        full_q[fill_bank] <= 1'b1;
                        fill_bank         <= ~fill_bank;
                        fill_ptr          <= '0;
                    end else begin
                        fill_ptr <= fill_ptr + 1'b1;
                    end
                end
            end

            if (idx_wr)
                fill_ptr <= PTR_W'(wbs_dat_i % MSG_WORDS);

            if (ops_wr && !wbs_dat_i[1]) begin
                on_q     <= wbs_dat_i[0];
                irq_en_q <= wbs_dat_i[2];
                if (wbs_dat_i[3]) begin
                    done_q     <= 1'b0;
                    overflow_q <= 1'b0;
                end
            end

            if (dig_rd)
                dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (on_q && (full_q != 2'b00)) begin
                        // With both banks full, the fill bank holds the older block.
                        run_bank   <= (full_q == 2'b11) ? fill_bank : full_q[1];
                        core_start <= 1'b1;
                        done_q     <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: state <= ST_RUN;
                ST_RUN: begin
                    if (core_done) begin
                        for (int d = 0; d < DIGEST_WORDS; d++)
                            digest_q[d] <= core_digest[d*32 +: 32];
                        full_q[run_bank] <= 1'b0;
                        done_q           <= 1'b1;
                        dig_idx          <= '0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Soft reset is last so it overrides every update above.
            if (soft_rst) begin
                full_q     <= '0;
                fill_bank  <= 1'b0;
                fill_ptr   <= '0;
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
                dig_idx    <= '0;
                core_start <= 1'b0;
                state      <= ST_IDLE;
            end
        end
    end

endmodule
